// File: rtl/isr_pkg.sv
// Shared types and constants for the interrupt sequencer.
package isr_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_RUN   = 3'd1,
        S_JISR  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERET  = 3'd4
    } isr_state_e;

    localparam int C_RESET = 0;
    localparam int C_ILL   = 1;
    localparam int C_MAL   = 2;
    localparam int C_PFF   = 3;
    localparam int C_PFLS  = 4;
    localparam int C_SYSC  = 5;
    localparam int C_OVF   = 6;
    localparam int C_EXT0  = 7;

    localparam logic [31:0] REPEAT_MASK_DEF   = 32'h0000_0018;
    localparam logic [31:0] MASKABLE_MASK_DEF = 32'hFFFF_FFC0;

endpackage

// File: rtl/isr_ctrl_if.sv
// Commit-side inputs and SPR-side outputs of the interrupt sequencer.
interface isr_ctrl_if;

    logic [6:0]  ca_int;
    logic        instr_done;
    logic        eret;
    logic [31:0] sr;
    logic        jisr;
    logic [31:0] mca;
    logic [4:0]  il;
    logic        rpt;
    logic        eret_go;
    logic        stall;
    logic [24:0] pend;

    modport master (
        output ca_int, instr_done, eret, sr,
        input  jisr, mca, il, rpt, eret_go, stall, pend
    );

    modport slave (
        input  ca_int, instr_done, eret, sr,
        output jisr, mca, il, rpt, eret_go, stall, pend
    );

endinterface

// File: rtl/isr_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module isr_prio_enc (
    input  logic [31:0] vec,
    output logic [4:0]  idx,
    output logic        valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = 5'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/isr_ctrl.sv
// Interrupt sequencer: cause masking, take/eret sequencing, ext capture.
// Optional ISR_EXT_SYNC_EN adds a 2-flop synchronizer on ext_irq.
module isr_ctrl
    import isr_pkg::*;
#(
    parameter int unsigned FLUSH_CYC     = 2,
    parameter logic [31:0] REPEAT_MASK   = REPEAT_MASK_DEF,
    parameter logic [31:0] MASKABLE_MASK = MASKABLE_MASK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [24:0] ext_irq,
    isr_ctrl_if.slave   bus
);

    isr_state_e  state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] mca_q, mca_n;
    logic [4:0]  il_q, il_n;
    logic        rpt_q, rpt_n;
    logic        jisr_q, eret_go_q, stall_q;
    logic [24:0] pend_q, pend_n;
    logic [24:0] prev_q, ext_s, rise;
    logic [31:0] cand;
    logic [4:0]  enc_idx;
    logic        enc_valid;

`ifdef ISR_EXT_SYNC_EN
    logic [24:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ext_irq;
            sync2_q <= sync1_q;
        end
    end

    assign ext_s = sync2_q;
`else
    assign ext_s = ext_irq;
`endif

    assign cand = {pend_q, bus.ca_int} & (~MASKABLE_MASK | bus.sr);

    isr_prio_enc u_enc (
        .vec   (cand),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // A fresh edge overrides the delivery clear on the same bit.
    assign rise = (state != S_RESET) ? (ext_s & ~prev_q) : '0;

    always_comb begin
        pend_n = pend_q;
        if (state == S_JISR)
            pend_n = pend_n & ~mca_q[31:C_EXT0];
        pend_n = pend_n | rise;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mca_n   = mca_q;
        il_n    = il_q;
        rpt_n   = rpt_q;
        unique case (state)
            S_RESET: begin
                state_n = S_JISR;
                mca_n   = 32'h1;
                il_n    = 5'(C_RESET);
                rpt_n   = 1'b0;
            end
            S_RUN: begin
                if (bus.instr_done && enc_valid) begin
                    state_n = S_JISR;
                    mca_n   = cand;
                    il_n    = enc_idx;
                    rpt_n   = REPEAT_MASK[enc_idx];
                end else if (bus.instr_done && bus.eret) begin
                    state_n = S_ERET;
                end
            end
            S_JISR: begin
                state_n = S_DRAIN;
                cnt_n   = 4'(FLUSH_CYC);
            end
            S_DRAIN: begin
                if (cnt <= 4'd1) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            S_ERET:  state_n = S_RUN;
            default: state_n = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            mca_q     <= '0;
            il_q      <= '0;
            rpt_q     <= 1'b0;
            jisr_q    <= 1'b0;
            eret_go_q <= 1'b0;
            stall_q   <= 1'b1;
            pend_q    <= '0;
            prev_q    <= '0;
        end else begin
            cnt       <= cnt_n;
            mca_q     <= mca_n;
            il_q      <= il_n;
            rpt_q     <= rpt_n;
            jisr_q    <= (state_n == S_JISR);
            eret_go_q <= (state_n == S_ERET);
            stall_q   <= (state_n != S_RUN);
            pend_q    <= pend_n;
            prev_q    <= ext_s;
        end
    end

    assign bus.jisr    = jisr_q;
    assign bus.mca     = mca_q;
    assign bus.il      = il_q;
    assign bus.rpt     = rpt_q;
    assign bus.eret_go = eret_go_q;
    assign bus.stall   = stall_q;
    assign bus.pend    = pend_q;

    // A commit while stalled is dropped by the FSM; flag it.
    a_no_commit_in_stall: assert property (
        @(posedge clk) disable iff (!rst_n) !(stall_q && bus.instr_done)
    );

endmodule

// File: doc/isr_ctrl.md
# isr_ctrl

Interrupt sequencer for the special-purpose-register file. Collects internal cause pulses and external interrupt lines, masks them against the status register, and decides at each instruction commit whether to take an interrupt. On a take, it drives the SPR block's `jisr`, `mca` and `rpt` inputs and stalls the pipeline while the PC redirect settles. It also sequences `eret` (restore of sr/pc from esr/epc) and issues the power-on reset interrupt.

## Interface
Parameters:
- FLUSH_CYC, 2: drain cycles after the JISR cycle; legal range is 1..15.
- REPEAT_MASK, 32'h0000_0018: cause bits of repeat type (page fault on fetch, page fault on load/store).
- MASKABLE_MASK, 32'hFFFF_FFC0: cause bits gated by sr. Bits 0..5 are never masked.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ca_int  in  7  internal causes of the committing instruction, mapped to cause bits 6..0. Bit 0 is unused and must be driven 0.
- ext_irq  in  25  external request lines, mapped to cause bits 31..7. Captured on rising edge.
- instr_done  in  1  an instruction commits this cycle.
- eret  in  1  the committing instruction is eret.
- sr  in  32  current status register; bit i enables maskable cause i.
- jisr  out  1  one-cycle interrupt-take strobe to the SPR block.
- mca  out  32  masked cause vector. Valid while jisr=1, held until the next take.
- il  out  5  index of the lowest set bit of mca, which is the highest-priority cause.
- rpt  out  1  1 when cause il is set in REPEAT_MASK.
- eret_go  out  1  one-cycle strobe: sr<=esr, pc<=epc.
- stall  out  1  freeze fetch/commit.
- pend  out  25  captured external requests not yet delivered.

## Operation
- States: RESET, RUN, JISR, DRAIN, ERET. The state encoding lives in the package.
- RESET:
  - Entered asynchronously whenever rst_n=0. Remains there until the first rising edge of clk with rst_n=1.
  - Goes to JISR with mca=32'h1, il=0, rpt=0. This is the reset interrupt.
- RUN:
  - Each cycle: cand = {pend, ca_int} & (~MASKABLE_MASK | sr).
  - If instr_done=1 and cand≠0:
    - latch mca<=cand, il<=lowest set index, rpt<=REPEAT_MASK[il];
    - go to JISR.
  - Else if instr_done=1 and eret=1: go to ERET.
  - If instr_done=0: ca_int and eret are ignored.
- JISR:
  - jisr=1 and stall=1 for exactly one cycle.
  - Clears the pend bits that were set in mca (bits 31..7).
  - Loads drain counter with FLUSH_CYC and goes to DRAIN.
- DRAIN:
  - stall=1; the counter decrements each cycle.
  - Goes to RUN in the cycle after the counter reaches 1.
  - instr_done during stall is a protocol violation. It is ignored and flagged by an assertion.
- ERET: eret_go=1 and stall=1 for one cycle, then RUN.
- External capture:
  - A 0→1 transition on ext_irq[k] sets pend[k].
  - pend[k] stays set until it is delivered in a JISR. A masked pend bit persists indefinitely.
  - If a new edge and a JISR clear hit the same bit in the same cycle, the set wins.
  - Capture continues in every state except RESET.
- Simultaneous events: a cause and eret on the same commit → interrupt taken and eret_go is never asserted. Several causes → all appear in mca; il and rpt follow the lowest index.

## Timing
- Commit with cause at cycle n → jisr=1 at cycle n+1. stall is high for cycles n+1 .. n+1+FLUSH_CYC.
- Commit with eret at cycle n → eret_go=1 and stall=1 at cycle n+1 only.
- ext_irq edge at cycle n → pend set at n+1 (n+3 with sync, see Configuration). Earliest possible take is the commit in the following cycle.
- Reset values: jisr=0, mca=0, il=0, rpt=0, eret_go=0, stall=1, pend=0, counter=0.
- Reset asserted mid-DRAIN, JISR or ERET → all outputs return to their reset values immediately, without waiting for a clock.
- All outputs are registered; no combinational path from input to output.

## Configuration
- ISR_EXT_SYNC_EN defined: each ext_irq line passes a 2-flop synchronizer before edge detection, adding 2 cycles of capture latency.
- ISR_EXT_SYNC_EN undefined: edge detection uses a single previous-value register directly on ext_irq. ext_irq must then be synchronous to clk.

## Structure
- Package isr_pkg holds:
  - the state enum;
  - cause-index constants (C_RESET=0, C_ILL=1, C_MAL=2, C_PFF=3, C_PFLS=4, C_SYSC=5, C_OVF=6, C_EXT0=7);
  - default REPEAT_MASK and MASKABLE_MASK.
- Sub-module isr_prio_enc: 32-bit lowest-set-bit encoder producing a 5-bit index plus a valid flag.

## Test plan
- Release rst_n → next edge jisr=1, mca=32'h1, il=0, rpt=0. stall=1 for 1+FLUSH_CYC=3 cycles, then 0.
- sr=0, instr_done=1, ca_int=7'h08 → next cycle jisr=1, mca=32'h8, il=3, rpt=1.
- sr=0, ext_irq[0] rising → pend=25'h1 and no jisr on commits. Set sr=32'h80 and commit → mca=32'h80, il=7, rpt=0, pend=0 after the JISR cycle.
- sr=32'hFFFF_FFFF, commit with ca_int=7'h44 → mca=32'h44, il=2, rpt=0.
- Commit with eret=1, no cause → eret_go=1 and stall=1 for one cycle. Commit with eret=1 and ca_int=7'h20 → jisr=1, mca=32'h20, eret_go stays 0.
- Assert rst_n=0 during DRAIN → jisr=0, mca=0, pend=0, stall=1 immediately. Release → reset interrupt (mca=32'h1) issued again.
